// File: rtl/instr_feeder_pkg.sv
// rtl/instr_feeder_pkg.sv - shared opcodes, word width and feeder state encoding
package instr_feeder_pkg;

    localparam int DATA_W = 9;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_IMMW,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
`ifdef FEEDER_SINGLE_STEP_EN
        , ST_STEPW
`endif
    } feeder_state_t;

    // Opcodes 100..110 have no proc implementation and would never raise Done.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2] && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/instr_feeder_pc.sv
// rtl/instr_feeder_pc.sv - program counter with reset load, +1/+2 steps and modulo wrap
module instr_feeder_pc #(
    parameter int ADDR_W   = 5,
    parameter int START_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc1,
    input  logic              i_inc2,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_p1
);

    logic [ADDR_W-1:0] r_pc;

    // Natural ADDR_W-bit overflow gives the wrap from 2**ADDR_W-1 to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= ADDR_W'(START_PC);
        end else if (i_inc2) begin
            r_pc <= r_pc + ADDR_W'(2);
        end else if (i_inc1) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc    = r_pc;
    assign o_pc_p1 = r_pc + ADDR_W'(1);

endmodule

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - fetch stage feeding proc DIN/Run from a sync ROM
// Optional single-step mode (Step input, STEPW state) when FEEDER_SINGLE_STEP_EN is defined.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int START_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_done,
`ifdef FEEDER_SINGLE_STEP_EN
    input  logic              i_step,
`endif
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_din,
    output logic              o_run,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_pc
);

    feeder_state_t     r_state;
    logic              r_lat;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_imm;

    logic [2:0]        w_op;
    logic              w_ir_mvi;
    logic              w_exec_done;
    logic              w_inc1;
    logic              w_inc2;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_p1;

    assign w_op        = i_mem_rdata[DATA_W-1 -: 3];
    assign w_ir_mvi    = (r_ir[DATA_W-1 -: 3] == OP_MVI);
    assign w_exec_done = (r_state == ST_EXEC) && i_done;
    assign w_inc2      = w_exec_done && w_ir_mvi;
    assign w_inc1      = (w_exec_done && !w_ir_mvi)
                       || ((r_state == ST_WAIT) && r_lat && is_illegal(w_op))
                       || ((r_state == ST_HALT) && i_start);

    instr_feeder_pc #(
        .ADDR_W   (ADDR_W),
        .START_PC (START_PC)
    ) u_pc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc1  (w_inc1),
        .i_inc2  (w_inc2),
        .o_pc    (w_pc),
        .o_pc_p1 (w_pc_p1)
    );

    assign o_pc = w_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_lat      <= 1'b0;
            r_ir       <= '0;
            r_imm      <= '0;
            o_mem_addr <= ADDR_W'(START_PC);
            o_din      <= '0;
            o_run      <= 1'b0;
            o_busy     <= 1'b0;
            o_halted   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_run <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_busy  <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    o_mem_addr <= w_pc;
                    r_lat      <= 1'b0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!r_lat) begin
                        // Present PC+1 while the opcode is still in flight so an mvi
                        // immediate is already on mem_rdata in IMMW.
                        r_lat      <= 1'b1;
                        o_mem_addr <= w_pc_p1;
                    end else begin
                        r_ir <= i_mem_rdata;
                        if (w_op == OP_HALT) begin
                            o_busy   <= 1'b0;
                            o_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (is_illegal(w_op)) begin
                            o_err   <= 1'b1;
                            r_state <= ST_FETCH;
                        end else if (w_op == OP_MVI) begin
                            r_state <= ST_IMMW;
                        end else begin
                            o_din   <= i_mem_rdata;
                            o_run   <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_IMMW: begin
                    r_imm   <= i_mem_rdata;
                    o_din   <= r_ir;
                    o_run   <= 1'b1;
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    o_din   <= w_ir_mvi ? r_imm : r_ir;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (i_done) begin
`ifdef FEEDER_SINGLE_STEP_EN
                        r_state <= ST_STEPW;
`else
                        r_state <= ST_FETCH;
`endif
                    end
                end
                ST_HALT: begin
                    if (i_start) begin
                        o_halted <= 1'b0;
                        o_busy   <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
`ifdef FEEDER_SINGLE_STEP_EN
                ST_STEPW: begin
                    if (i_step) begin
                        r_state <= ST_FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - self-checking bench: ROM + behavioural proc around instr_feeder
module tb_instr_feeder;

    localparam int AW  = 5;
    localparam int LIM = 2000;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [8:0]    rdata;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic [8:0]    din;
    logic          run, busy, halted, err;
`ifdef FEEDER_SINGLE_STEP_EN
    logic          step = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_feeder #(.ADDR_W(AW), .START_PC(0)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_done      (done),
`ifdef FEEDER_SINGLE_STEP_EN
        .i_step      (step),
`endif
        .i_mem_rdata (rdata),
        .o_mem_addr  (mem_addr),
        .o_din       (din),
        .o_run       (run),
        .o_busy      (busy),
        .o_halted    (halted),
        .o_err       (err),
        .o_pc        (pc)
    );

    // Synchronous-read program ROM
    logic [8:0] rom [32];
    always @(posedge clk) rdata <= rom[mem_addr];

    // Behavioural proc: T0 waits for Run, mv/mvi finish in T1, add/sub in T3
    logic [8:0] R [8] = '{default: 9'd0};
    logic [1:0] t    = 2'd0;
    logic [8:0] ir_p = 9'd0;
    logic [8:0] a_p  = 9'd0;
    logic [8:0] g_p  = 9'd0;
    always @(posedge clk) begin
        if (!rst_n) begin
            t <= 2'd0;
        end else begin
            case (t)
                2'd0: if (run) begin ir_p <= din; t <= 2'd1; end
                2'd1: begin
                    case (ir_p[8:6])
                        3'b000:  begin R[ir_p[5:3]] <= R[ir_p[2:0]]; t <= 2'd0; end
                        3'b001:  begin R[ir_p[5:3]] <= din;          t <= 2'd0; end
                        default: begin a_p <= R[ir_p[5:3]];          t <= 2'd2; end
                    endcase
                end
                2'd2: begin
                    g_p <= (ir_p[8:6] == 3'b010) ? a_p + R[ir_p[2:0]] : a_p - R[ir_p[2:0]];
                    t   <= 2'd3;
                end
                default: begin R[ir_p[5:3]] <= g_p; t <= 2'd0; end
            endcase
        end
    end
    assign done = ((t == 2'd1) && (ir_p[8:7] == 2'b00)) || (t == 2'd3);

    // Issue monitor
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [8:0]    q_word[$];
    logic [8:0]    q_t1[$];
    int            q_cyc[$];
    logic [AW-1:0] q_addr[$];
    logic          run_d = 1'b0;
    always @(negedge clk) begin
        if (run_d) q_t1.push_back(din);
        if (run) begin
            q_word.push_back(din);
            q_cyc.push_back(cyc);
            q_addr.push_back(mem_addr);
        end
        run_d <= run;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: interprets the ROM from pc0 until HALT
    logic [8:0] e_word[$];
    logic [8:0] e_t1[$];
    int         e_gap[$];
    logic       e_err;
    int         e_pc;
    logic [8:0] eR [8] = '{default: 9'd0};

    task automatic ref_run(input int pc0);
        int p, pend;
        logic [8:0] w;
        logic [2:0] op;
        e_word.delete(); e_t1.delete(); e_gap.delete();
        e_err = 1'b0;
        p     = pc0;
        pend  = 0;
        for (int n = 0; n < 64; n++) begin
            w  = rom[p];
            op = w[8:6];
            if (op == 3'b111) break;
            if (op[2]) begin
                e_err = 1'b1;
                pend += 3;
                p = (p + 1) % 32;
            end else begin
                e_word.push_back(w);
                e_gap.push_back(pend + ((op == 3'b001) ? 1 : 0));
                pend = 5 + ((op[1]) ? 2 : 0);
                case (op)
                    3'b000: eR[w[5:3]] = eR[w[2:0]];
                    3'b001: eR[w[5:3]] = rom[(p + 1) % 32];
                    3'b010: eR[w[5:3]] = eR[w[5:3]] + eR[w[2:0]];
                    default: eR[w[5:3]] = eR[w[5:3]] - eR[w[2:0]];
                endcase
                e_t1.push_back((op == 3'b001) ? rom[(p + 1) % 32] : w);
                p = (p + ((op == 3'b001) ? 2 : 1)) % 32;
            end
        end
        e_pc = p;
    endtask

    task automatic cmp_run(input string tag, input int b);
        int n = q_word.size() - b;
        chk({tag, ".issues"}, n, e_word.size());
        for (int i = 0; i < e_word.size() && i < n; i++) begin
            chk({tag, ".word"}, q_word[b+i], e_word[i]);
            if (b + i < q_t1.size()) chk({tag, ".t1_din"}, q_t1[b+i], e_t1[i]);
            if (i > 0) chk({tag, ".gap"}, q_cyc[b+i] - q_cyc[b+i-1], e_gap[i]);
        end
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".busy"}, busy, 0);
        for (int r = 0; r < 8; r++) chk({tag, ".reg"}, R[r], eR[r]);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic go(input string tag, input bit poke);
        int k = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!halted && k < LIM) begin
            @(negedge clk);
            k++;
            start = poke && (k == 20);
        end
        start = 1'b0;
        chk({tag, ".halted"}, halted, 1);
    endtask

    task automatic fill(input logic [8:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    task automatic gen_prog();
        int a = 0;
        int k;
        logic [2:0] op, x, y;
        fill(9'o700);
        for (int r = 0; r < 4; r++) begin
            rom[a] = {3'b001, 3'(r), 3'b000};
            rom[a+1] = 9'($urandom);
            a += 2;
        end
        while (a < 28) begin
            k  = $urandom_range(0, 9);
            x  = 3'($urandom_range(0, 3));
            y  = 3'($urandom_range(0, 3));
            op = (k < 3) ? 3'b000 : (k < 5) ? 3'b001 : (k < 7) ? 3'b010 :
                 (k < 9) ? 3'b011 : 3'(4 + $urandom_range(0, 2));
            rom[a] = {op, x, y};
            if (op == 3'b001) begin rom[a+1] = 9'($urandom); a += 2; end
            else a++;
        end
    endtask

    initial begin
        int b, k;
        fill(9'o700);
        do_reset();

        // Reset state
        chk("rst.run", run, 0);
        chk("rst.busy", busy, 0);
        chk("rst.halted", halted, 0);
        chk("rst.err", err, 0);
        chk("rst.pc", pc, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.din", din, 0);

        // mvi R0,5 ; mv R1,R0 ; HALT
        fill(9'o700);
        rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o010; rom[3] = 9'o700;
        ref_run(0); b = q_word.size();
        go("p1", 1'b0);
        cmp_run("p1", b);
        chk("p1.r1", R[1], 5);
        chk("p1.pc3", pc, 3);

        // mvi R0,3 ; mvi R1,4 ; add R0,R1 ; sub R0,R1 ; HALT
        do_reset();
        fill(9'o700);
        rom[0] = 9'o100; rom[1] = 9'd3; rom[2] = 9'o110; rom[3] = 9'd4;
        rom[4] = 9'o201; rom[5] = 9'o301;
        ref_run(0); b = q_word.size();
        go("p2", 1'b0);
        cmp_run("p2", b);
        chk("p2.r0", R[0], 3);
        if (q_word.size() >= b + 4) chk("p2.gap_add_sub", q_cyc[b+3] - q_cyc[b+2], 7);

        // Illegal opcode skipped, then HALT
        do_reset();
        fill(9'o700);
        rom[0] = 9'o500;
        ref_run(0); b = q_word.size();
        go("p3", 1'b0);
        cmp_run("p3", b);
        chk("p3.err", err, 1);

        // Wrap: mvi at the last address takes its immediate from address 0
        do_reset();
        fill(9'o000);
        rom[30] = 9'o700; rom[31] = 9'o120;
        ref_run(0); b = q_word.size();
        go("wrap_a", 1'b0);
        cmp_run("wrap_a", b);
        rom[0] = 9'($urandom); rom[1] = 9'o700;
        ref_run(31); b = q_word.size();
        go("wrap_b", 1'b0);
        cmp_run("wrap_b", b);
        if (q_addr.size() > b) chk("wrap.mem_addr", q_addr[b], 0);

        // Randomised programs, with a stray Start pulse mid-run
        for (int n = 0; n < 3; n++) begin
            do_reset();
            gen_prog();
            ref_run(0); b = q_word.size();
            go("rand", 1'b1);
            cmp_run("rand", b);
        end

        // Reset during ISSUE and during add's T2, then clean restart
        do_reset();
        fill(9'o700);
        rom[0] = 9'o100; rom[1] = 9'd3; rom[2] = 9'o110; rom[3] = 9'd4;
        rom[4] = 9'o201; rom[5] = 9'o301;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!run && k < LIM) begin @(negedge clk); k++; end
        chk("rst_issue.seen", run, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_issue.run", run, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!(t == 2'd2 && ir_p[8:6] == 3'b010) && k < LIM) begin @(negedge clk); k++; end
        chk("rst_t2.seen", t, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_t2.run", run, 0);
        chk("rst_t2.pc", pc, 0);
        chk("rst_t2.busy", busy, 0);
        @(posedge clk) #1;
        chk("rst_t2.proc_t0", t, 0);
        @(negedge clk) rst_n = 1'b1;
        ref_run(0); b = q_word.size();
        go("restart", 1'b0);
        cmp_run("restart", b);

`ifdef FEEDER_SINGLE_STEP_EN
        // Single step: one instruction per Step pulse
        do_reset();
        fill(9'o700);
        rom[0] = 9'o045; rom[1] = 9'o056;
        b = q_word.size();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        chk("step.first", q_word.size() - b, 1);
        step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (20) @(negedge clk);
        chk("step.second", q_word.size() - b, 2);
        chk("step.not_halted", halted, 0);
        step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (20) @(negedge clk);
        chk("step.halted", halted, 1);
        chk("step.count", q_word.size() - b, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
